// File: rtl/ov7670_config_sequencer_if.sv
// ----------------------------------------------------------------------------
// ov7670_config_sequencer_if
//
// Register-write handshake between the OV7670 configuration sequencer and the
// SCCB write controller.
//   wr_req       sequencer -> controller : write request, held until wr_ack
//   wr_reg_addr  sequencer -> controller : register address, stable until wr_done
//   wr_reg_data  sequencer -> controller : register data, stable until wr_done
//   wr_ack       controller -> sequencer : request accepted
//   wr_done      controller -> sequencer : one-cycle pulse, transaction finished
//   wr_nack      controller -> sequencer : slave NACK, meaningful with wr_done
// modport master is the sequencer side, modport slave the controller side.
// ----------------------------------------------------------------------------
interface ov7670_config_sequencer_if;
  logic       wr_req;
  logic [7:0] wr_reg_addr;
  logic [7:0] wr_reg_data;
  logic       wr_ack;
  logic       wr_done;
  logic       wr_nack;

  modport master (
    output wr_req, wr_reg_addr, wr_reg_data,
    input  wr_ack, wr_done, wr_nack
  );

  modport slave (
    input  wr_req, wr_reg_addr, wr_reg_data,
    output wr_ack, wr_done, wr_nack
  );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// ----------------------------------------------------------------------------
// ov7670_config_sequencer
//
// Walks the OV7670 register-configuration ROM and hands each address/data pair
// to the SCCB write controller. 16'hFFFF ends the table, 16'hFFF0 inserts a
// settle delay of DELAY_CYCLES clocks. NACKed writes are retried up to
// MAX_RETRIES extra times before the pass is abandoned.
//
// Ports
//   clk                clock, rising edge
//   reset              asynchronous active-low reset
//   i_start            one-cycle pulse, starts a pass when idle
//   o_rom_addr         ROM address (ROM answers one cycle later)
//   i_rom_dout         ROM data: [15:8] register address, [7:0] register data
//   wr                 write handshake to the SCCB controller (master side)
//   o_busy             pass in progress
//   o_done             level, last pass completed
//   o_error            level, last pass ran out of retries
//   o_entries_written  ACKed writes in the current/last pass (saturating)
// ----------------------------------------------------------------------------
module ov7670_config_sequencer #(
  parameter int ROM_DEPTH    = 256,
  parameter int DELAY_CYCLES = 500_000,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_start,
  output logic [7:0]                       o_rom_addr,
  input  logic [15:0]                      i_rom_dout,
  ov7670_config_sequencer_if.master        wr,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_error,
  output logic [7:0]                       o_entries_written
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_REQ       = 4'd3;
  localparam logic [3:0] S_WAIT_DONE = 4'd4;
  localparam logic [3:0] S_DELAY     = 4'd5;
  localparam logic [3:0] S_ADVANCE   = 4'd6;
  localparam logic [3:0] S_FINISH    = 4'd7;
  localparam logic [3:0] S_FAIL      = 4'd8;

  localparam logic [15:0] END_MARKER   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARKER = 16'hFFF0;

  // Delay counter holds DELAY_CYCLES-1 down to 0, retry counter 0..MAX_RETRIES.
  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [DW-1:0] DELAY_LOAD = DW'(DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [7:0]    LAST_ADDR  = 8'(ROM_DEPTH - 1);

  logic [3:0]    r_state;
  logic [7:0]    r_rom_addr;
  logic [RW-1:0] r_retry_cnt;
  logic [DW-1:0] r_delay_cnt;
  logic          r_wr_req;
  logic [7:0]    r_wr_reg_addr;
  logic [7:0]    r_wr_reg_data;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic [7:0]    r_entries_written;

  // NOTE: every register, including the datapath latches, is cleared by the
  // asynchronous reset so a reset mid-pass leaves no partial state behind and
  // wr_req falls without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= S_IDLE;
      r_rom_addr        <= '0;
      r_retry_cnt       <= '0;
      r_delay_cnt       <= '0;
      r_wr_req          <= 1'b0;
      r_wr_reg_addr     <= '0;
      r_wr_reg_data     <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_error           <= 1'b0;
      r_entries_written <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // state as it was before this edge regardless of statement order.
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rom_addr        <= '0;
            r_retry_cnt       <= '0;
            r_entries_written <= '0;
            r_done            <= 1'b0;
            r_error           <= 1'b0;
            r_busy            <= 1'b1;
            r_state           <= S_FETCH;
          end
        end

        // ROM data for the new address arrives one cycle after it changes.
        S_FETCH: r_state <= S_DECODE;

        S_DECODE: begin
          if (i_rom_dout == END_MARKER) begin
            r_state <= S_FINISH;
          end else if (i_rom_dout == DELAY_MARKER) begin
            r_delay_cnt <= DELAY_LOAD;
            r_state     <= S_DELAY;
          end else begin
            r_wr_reg_addr <= i_rom_dout[15:8];
            r_wr_reg_data <= i_rom_dout[7:0];
            r_wr_req      <= 1'b1;
            r_state       <= S_REQ;
          end
        end

        // A wr_done arriving before the ack is not ours and is ignored.
        S_REQ: begin
          if (wr.wr_ack) begin
            r_wr_req <= 1'b0;
            r_state  <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (wr.wr_done) begin
            if (!wr.wr_nack) begin
              if (r_entries_written != 8'hFF) begin
                r_entries_written <= r_entries_written + 8'd1;
              end
              r_state <= S_ADVANCE;
            end else if (r_retry_cnt < RETRY_MAX) begin
              // Address/data registers are untouched, so the retry repeats
              // the exact same write.
              r_retry_cnt <= r_retry_cnt + RW'(1);
              r_wr_req    <= 1'b1;
              r_state     <= S_REQ;
            end else begin
              r_state <= S_FAIL;
            end
          end
        end

        S_DELAY: begin
          if (r_delay_cnt == '0) begin
            r_state <= S_ADVANCE;
          end else begin
            r_delay_cnt <= r_delay_cnt - DW'(1);
          end
        end

        // The last ROM index finishes the pass instead of wrapping to 0.
        S_ADVANCE: begin
          r_retry_cnt <= '0;
          if (r_rom_addr == LAST_ADDR) begin
            r_state <= S_FINISH;
          end else begin
            r_rom_addr <= r_rom_addr + 8'd1;
            r_state    <= S_FETCH;
          end
        end

        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        S_FAIL: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rom_addr        = r_rom_addr;
  assign wr.wr_req         = r_wr_req;
  assign wr.wr_reg_addr    = r_wr_reg_addr;
  assign wr.wr_reg_data    = r_wr_reg_data;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_entries_written = r_entries_written;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ov7670_config_sequencer
//
// Drives the sequencer against a small ROM and a behavioural SCCB controller.
// For each pass a reference model walks the ROM table by the marker/retry
// rules and predicts the ordered write transactions, the NACK answer for each,
// the cycle distance to each request, and the final done/error/count/address.
// ----------------------------------------------------------------------------
module tb_ov7670_config_sequencer;

  localparam int DEPTH = 4;
  localparam int DLY   = 5;
  localparam int MAXR  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  entries;

  ov7670_config_sequencer_if wr_if ();

  ov7670_config_sequencer #(
    .ROM_DEPTH    (DEPTH),
    .DELAY_CYCLES (DLY),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .i_start           (i_start),
    .o_rom_addr        (rom_addr),
    .i_rom_dout        (rom_dout),
    .wr                (wr_if),
    .o_busy            (busy),
    .o_done            (done),
    .o_error           (error),
    .o_entries_written (entries)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data follows the address by one clock.
  logic [15:0] rom [DEPTH];
  always @(posedge clk) rom_dout <= (rom_addr < 8'(DEPTH)) ? rom[rom_addr[1:0]] : 16'hFFFF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference-model outputs
  logic [15:0] exp_txn [$];
  bit          nack_q  [$];
  int          lat_q   [$];
  int          nacks   [DEPTH];
  int          exp_writes;
  bit          exp_err;
  int          exp_last;

  // Controller behaviour knobs (-1 = random)
  int ack_dly_fix  = -1;
  int done_dly_fix = -1;
  int t_last = 0;
  int phase  = 0;

  // Expected behaviour of one pass, from the table rules: markers cost
  // FETCH+DECODE+delay+ADVANCE, a new entry's request comes 3 cycles after the
  // previous wr_done (4 sample points), a retry comes right after wr_done.
  task automatic build_model();
    int  k;
    bit  first;
    int  nk;
    int  att;
    exp_txn.delete();
    nack_q.delete();
    lat_q.delete();
    exp_writes = 0;
    exp_err    = 1'b0;
    exp_last   = 0;
    k          = 0;
    first      = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_last = i;
      if (rom[i] == 16'hFFFF) break;
      if (rom[i] == 16'hFFF0) begin
        k++;
        continue;
      end
      nk  = nacks[i];
      att = (nk > MAXR) ? MAXR + 1 : nk + 1;
      for (int a = 0; a < att; a++) begin
        exp_txn.push_back(rom[i]);
        nack_q.push_back(a < nk);
        lat_q.push_back((a > 0) ? 1 : ((first ? 3 : 4) + k * (DLY + 3)));
      end
      first = 1'b0;
      k     = 0;
      if (nk > MAXR) begin
        exp_err = 1'b1;
        break;
      end
      exp_writes++;
    end
  endtask

  // Behavioural SCCB write controller, acting on falling edges.
  initial begin : responder
    logic [15:0] cur;
    int          cnt;
    cur = '0;
    cnt = 0;
    wr_if.wr_ack  = 1'b0;
    wr_if.wr_done = 1'b0;
    wr_if.wr_nack = 1'b0;
    forever begin
      @(negedge clk);
      wr_if.wr_ack  = 1'b0;
      wr_if.wr_done = 1'b0;
      wr_if.wr_nack = 1'b0;
      if (!reset) begin
        phase = 0;
      end else begin
        case (phase)
          0: begin
            if (wr_if.wr_req) begin
              cur = {wr_if.wr_reg_addr, wr_if.wr_reg_data};
              if (exp_txn.size() > 0) check("txn", 32'(cur), 32'(exp_txn.pop_front()));
              else check("extra_txn", 32'(exp_txn.size()), 32'd1);
              if (lat_q.size() > 0) check("req_latency", 32'(cyc - t_last), 32'(lat_q.pop_front()));
              cnt = (ack_dly_fix >= 0) ? ack_dly_fix : int'($urandom_range(0, 4));
              if (cnt == 0) begin
                wr_if.wr_ack = 1'b1;
                phase = 2;
              end else begin
                phase = 1;
              end
            end
          end
          1: begin
            check("req_hold", 32'(wr_if.wr_req), 32'd1);
            check("data_hold", 32'({wr_if.wr_reg_addr, wr_if.wr_reg_data}), 32'(cur));
            cnt--;
            if (cnt == 0) begin
              wr_if.wr_ack = 1'b1;
              phase = 2;
            end
          end
          2: begin
            check("req_drop", 32'(wr_if.wr_req), 32'd0);
            cnt = (done_dly_fix >= 0) ? done_dly_fix : int'($urandom_range(0, 3));
            if (cnt == 0) begin
              wr_if.wr_done = 1'b1;
              wr_if.wr_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
              t_last = cyc;
              phase = 0;
            end else begin
              phase = 3;
            end
          end
          default: begin
            cnt--;
            if (cnt == 0) begin
              wr_if.wr_done = 1'b1;
              wr_if.wr_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
              t_last = cyc;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic start_pass();
    build_model();
    @(negedge clk);
    i_start = 1'b1;
    t_last  = cyc;
    @(negedge clk);
    i_start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("done_clr", 32'(done), 32'd0);
    check("error_clr", 32'(error), 32'd0);
  endtask

  task automatic finish_pass(input bit mid_start);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
      i_start = (mid_start && n == 6);
    end
    i_start = 1'b0;
    check("pass_end_busy", 32'(busy), 32'd0);
    check("done", 32'(done), 32'(!exp_err));
    check("error", 32'(error), 32'(exp_err));
    check("entries", 32'(entries), 32'(exp_writes));
    check("rom_addr", 32'(rom_addr), 32'(exp_last));
    check("txn_left", 32'(exp_txn.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_pass(input bit mid_start);
    start_pass();
    finish_pass(mid_start);
  endtask

  task automatic set_rom(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    for (int i = 0; i < DEPTH; i++) nacks[i] = 0;
  endtask

  initial begin : main
    int n;
    int r;
    set_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    reset = 1'b0;
    #1;
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_wr_req", 32'(wr_if.wr_req), 32'd0);
    check("rst_wr_addr", 32'(wr_if.wr_reg_addr), 32'd0);
    check("rst_wr_data", 32'(wr_if.wr_reg_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_entries", 32'(entries), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Write, delay marker, write, end marker; controller always ACKs.
    set_rom(16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF);
    run_pass(1'b0);

    // Two NACKs then ACK on entry 0.
    set_rom(16'h1280, 16'hFFFF, 16'h1111, 16'h2222);
    nacks[0] = 2;
    run_pass(1'b0);

    // Entry 0 never ACKed: four attempts then failure at address 0.
    set_rom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
    nacks[0] = 4;
    run_pass(1'b0);

    // No end marker: stops at the last index without wrapping.
    set_rom(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    run_pass(1'b0);

    // Slow ack with a start pulse during the pass.
    set_rom(16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF);
    ack_dly_fix = 5;
    run_pass(1'b1);
    ack_dly_fix = -1;

    // Reset asserted while waiting for wr_done of the second write.
    set_rom(16'h1280, 16'h1204, 16'h1208, 16'hFFFF);
    done_dly_fix = 30;
    ack_dly_fix  = 0;
    start_pass();
    n = 0;
    while (!(entries == 8'd1 && phase == 3) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_entries", 32'(entries), 32'd1);
    check("pre_rst_rom_addr", 32'(rom_addr), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_wr_req", 32'(wr_if.wr_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_entries", 32'(entries), 32'd0);
    check("async_rst_rom_addr", 32'(rom_addr), 32'd0);
    check("async_rst_wr_addr", 32'(wr_if.wr_reg_addr), 32'd0);
    repeat (3) @(negedge clk);
    exp_txn.delete();
    nack_q.delete();
    lat_q.delete();
    done_dly_fix = -1;
    ack_dly_fix  = -1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_pass(1'b0);

    // Randomized tables, NACK patterns and controller timing.
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) rom[i] = 16'hFFFF;
        else if (r == 1) rom[i] = 16'hFFF0;
        else rom[i] = 16'($urandom_range(0, 32'hFFEF));
        r = int'($urandom_range(0, 9));
        nacks[i] = (r < 7) ? 0 : (r < 9) ? int'($urandom_range(1, 3)) : 4;
      end
      run_pass(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
